// File: rtl/shift_pkg.sv
// Shared definitions for the shift_reg_seq register slice:
// mode encodings, sequencer state encodings and a mode-class helper.
package shift_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // True for the modes that move bits and produce an out bit.
    function automatic logic is_shift(input logic [2:0] mode);
        return (mode >= MODE_SHL) && (mode <= MODE_ASR);
    endfunction

endpackage

// File: rtl/shift_step_core.sv
// Combinational single step: next register value and out bit for a mode.
// Ports: mode, q (current), d (load data), ser_in -> q_next, out_bit.
module shift_step_core
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q_next,
    output logic             out_bit
);

    always_comb begin
        q_next  = q;
        out_bit = 1'b0;
        unique case (mode)
            MODE_HOLD: q_next = q;
            MODE_LOAD: q_next = d;
            MODE_SHL: begin
                q_next  = {q[WIDTH-2:0], ser_in};
                out_bit = q[WIDTH-1];
            end
            MODE_SHR: begin
                q_next  = {ser_in, q[WIDTH-1:1]};
                out_bit = q[0];
            end
            MODE_ROL: begin
                q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
                out_bit = q[WIDTH-1];
            end
            MODE_ROR: begin
                q_next  = {q[0], q[WIDTH-1:1]};
                out_bit = q[0];
            end
            MODE_ASR: begin
                q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
                out_bit = q[0];
            end
            MODE_CLR: q_next = '0;
        endcase
    end

endmodule

// File: rtl/shift_reg_seq.sv
// Universal shift register with a multi-step shift sequencer.
// Ports: Clk, Resetn, En, Mode, D, SerIn, Start, Amount -> Q, SerOut, Busy, Done.
module shift_reg_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             Resetn,
    input  logic             En,
    input  logic [2:0]       Mode,
    input  logic [WIDTH-1:0] D,
    input  logic             SerIn,
    input  logic             Start,
    input  logic [CNT_W-1:0] Amount,
    output logic [WIDTH-1:0] Q,
    output logic             SerOut,
    output logic             Busy,
    output logic             Done
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             ser_q, ser_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [2:0]       op_mode;
    logic [WIDTH-1:0] step_q;
    logic             step_out;

    // One step core serves both the direct path and the sequencer.
    assign op_mode = (state_q == ST_RUN) ? mode_q : Mode;

    shift_step_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .mode    (op_mode),
        .q       (q_q),
        .d       (D),
        .ser_in  (SerIn),
        .q_next  (step_q),
        .out_bit (step_out)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        q_d     = q_q;
        ser_d   = ser_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (Start && is_shift(Mode)) begin
                    mode_d = Mode;
                    if (Amount == '0) begin
                        done_d = 1'b1;
                    end else begin
                        cnt_d   = Amount;
                        state_d = ST_RUN;
                        busy_d  = 1'b1;
                    end
                end else if (Start || En) begin
                    // Non-shift Start degrades to a plain direct op.
                    q_d = step_q;
                    if (is_shift(Mode)) ser_d = step_out;
                end
            end
            ST_RUN: begin
                q_d   = step_q;
                ser_d = step_out;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_HOLD;
            q_q     <= '0;
            ser_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            q_q     <= q_d;
            ser_q   <= ser_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Q      = q_q;
    assign SerOut = ser_q;
    assign Busy   = busy_q;
    assign Done   = done_q;

endmodule
